count_bcd_display: RTL and testbench
====================================

// Module: count_bcd_display
// PURPOSE
//  Consumes the 7-bit binary value of the upstream 7-bit counter (0..127).
//  On request, converts it to 3-digit BCD with a sequential shift-add-3 (double-dabble) engine.
//  Drives a time-multiplexed 3-digit seven-segment display with leading-zero blanking.
//  Sits directly downstream of the counter, between it and the board display pins.
// PARAMETERS
//  DATA_W    7   width of binary input; fixed at 7 for this block
//  SCAN_DIV  4   clk cycles each digit is enabled before the scan advances (>=1)
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  reset      in   1   synchronous, active-high reset
//  q_in       in   7   binary count from upstream counter
//  load       in   1   conversion request; sampled only while busy=0
//  busy       out  1   conversion in progress
//  bcd        out  12  latched result {hundreds,tens,units}, 4 bits each
//  bcd_valid  out  1   one-cycle pulse when bcd is updated
//  seg        out  7   segment drive {g,f,e,d,c,b,a}, active high
//  an         out  3   one-hot digit enable; an[0]=units, an[1]=tens, an[2]=hundreds
// BEHAVIOUR
//  Reset values
//  - At a rising edge with reset=1: busy=0, bcd_valid=0, bcd=12'h000.
//  - Same edge: scan counter=0, digit index=0; an=3'b001, seg=7'h3F.
//  - reset has priority over every other input.
//  Conversion FSM, states IDLE and SHIFT
//  - IDLE with load=1 at edge k:
//    - capture q_in into the shift register and clear the BCD scratch;
//    - enter SHIFT with iteration count 0; busy=1 after edge k.
//  - Each SHIFT edge, in this order:
//    - add 3 to every scratch nibble >=5;
//    - shift {scratch,bin} left by 1;
//    - increment the iteration count.
//  - Edge k+7 (7th shift): bcd<=result, bcd_valid=1 for exactly that cycle, busy=0, state->IDLE.
//  - Latency: load at edge k -> bcd valid after edge k+7; busy is high for 7 cycles.
//  - load while busy=1 is ignored. This includes the cycle of edge k+7; no queuing.
//  - A new load is accepted at edge k+8 at the earliest.
//  - bcd holds its value between conversions.
//  - Reset mid-SHIFT: conversion abandoned, no bcd_valid pulse, bcd=000.
//  - Result range 000..127: hundreds is 0..1; tens and units are 0..9.
//  Display scan (free-running, independent of FSM)
//  - scan counter counts 0..SCAN_DIV-1 and wraps.
//  - On wrap, the digit index advances 0->1->2->0.
//  - an = one-hot of the digit index.
//  - seg = combinational decode of the selected nibble of the latched bcd.
//  - The display never shows scratch contents.
//  - Decode table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; nibble >9 -> 00.
//  - Blanking:
//    - hundreds digit shows 00 when hundreds=0;
//    - tens digit shows 00 when hundreds=0 and tens=0;
//    - units digit is never blanked.
//  - A bcd update takes effect on seg in the same cycle; the scan position is not disturbed.
// TESTING
//  1. Reset for 2 cycles -> busy=0, bcd_valid=0, bcd=000, an=001, seg=3F.
//  2. q_in=127, load 1 cycle -> busy=1 for 7 cycles; single bcd_valid pulse at 7th edge; bcd=12'h127.
//  3. Sweep q_in=0,9,10,99,100 -> bcd=000,009,010,099,100; exactly one bcd_valid pulse per load.
//  4. bcd=105, SCAN_DIV=4 -> an=001/010/100 for 4 cycles each, repeating; seg=6D/3F/06.
//     Then bcd=005 -> tens and hundreds seg=00.
//  5. load q_in=42, then load q_in=7 during busy (and at the completion cycle) -> bcd=042 only, one pulse.
//  6. load q_in=88, reset at 3rd SHIFT cycle -> busy=0 next cycle, no bcd_valid, bcd=000.
//     Then a fresh load converts correctly.

Source files
------------

// File: rtl/count_bcd_display.sv
// Converts a 7-bit binary count to 3-digit BCD with a sequential double-dabble engine
// and drives a time-multiplexed, leading-zero-blanked 3-digit seven-segment display.
module count_bcd_display #(
    parameter int DATA_W   = 7,
    parameter int SCAN_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] q_in,
    input  logic              load,
    output logic              busy,
    output logic [11:0]       bcd,
    output logic              bcd_valid,
    output logic [6:0]        seg,
    output logic [2:0]        an
);

    localparam int ITER_W = $clog2(DATA_W);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   bin_q, bin_d;
    logic [11:0]         scratch_q, scratch_d;
    logic [11:0]         adj;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [11:0]         bcd_q, bcd_d;
    logic                valid_q, valid_d;
    logic [SCAN_W-1:0]   scan_q, scan_d;
    logic [1:0]          digit_q, digit_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; next-state logic lives in always_comb with blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
            scan_q    <= '0;
            digit_q   <= '0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            iter_q    <= iter_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
            scan_q    <= scan_d;
            digit_q   <= digit_d;
        end
    end

    // Add-3 correction applied to each scratch nibble before the shift.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 3; i++) begin
            if (scratch_q[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        iter_d    = iter_q;
        bcd_d     = bcd_q;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d     = q_in;
                    scratch_d = '0;
                    iter_d    = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {adj[10:0], bin_q[DATA_W-1]};
                bin_d     = {bin_q[DATA_W-2:0], 1'b0};
                iter_d    = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(DATA_W - 1)) begin
                    bcd_d   = {adj[10:0], bin_q[DATA_W-1]};
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running digit scan, unaffected by the conversion engine.
    always_comb begin
        scan_d  = scan_q + SCAN_W'(1);
        digit_d = digit_q;
        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_d  = '0;
            digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    logic hund_zero, tens_zero;
    assign hund_zero = (bcd_q[11:8] == 4'd0);
    assign tens_zero = (bcd_q[7:4] == 4'd0);

    always_comb begin
        an  = 3'b001;
        seg = seg7(bcd_q[3:0]);
        case (digit_q)
            2'd1: begin
                an  = 3'b010;
                seg = (hund_zero && tens_zero) ? 7'h00 : seg7(bcd_q[7:4]);
            end
            2'd2: begin
                an  = 3'b100;
                seg = hund_zero ? 7'h00 : seg7(bcd_q[11:8]);
            end
            default: ;
        endcase
    end

    assign busy      = (state_q == SHIFT);
    assign bcd       = bcd_q;
    assign bcd_valid = valid_q;

endmodule

// File: tb/tb_count_bcd_display.sv
// Directed bench for count_bcd_display: conversion latency, results, scan and blanking,
// load-while-busy rejection and reset during a conversion.
module tb_count_bcd_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  q_in;
    logic        load;
    logic        busy;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic [6:0]  seg;
    logic [2:0]  an;

    int tests = 0;
    int fails = 0;

    count_bcd_display #(.DATA_W(7), .SCAN_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .q_in      (q_in),
        .load      (load),
        .busy      (busy),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Load one value and check busy for 7 cycles, a single valid pulse and the result.
    task automatic do_convert(input logic [6:0] val, input logic [11:0] exp_bcd);
        q_in = val;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("busy_during", {11'd0, busy}, 12'd1);
            check("valid_during", {11'd0, bcd_valid}, 12'd0);
            tick();
        end
        check("busy_done", {11'd0, busy}, 12'd0);
        check("valid_pulse", {11'd0, bcd_valid}, 12'd1);
        check("bcd_result", bcd, exp_bcd);
        tick();
        check("valid_single", {11'd0, bcd_valid}, 12'd0);
        check("bcd_hold", bcd, exp_bcd);
    endtask

    // Align to the first cycle of the units digit, then check reps full scan rounds.
    task automatic check_scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                              input int reps);
        logic       found;
        logic [2:0] prev;
        logic [2:0] exp_an;
        logic [6:0] exp_seg;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            prev = an;
            tick();
            if (prev == 3'b100 && an == 3'b001) begin
                found = 1'b1;
                break;
            end
        end
        check("scan_sync", {11'd0, found}, 12'd1);
        for (int r = 0; r < reps; r++) begin
            for (int d = 0; d < 3; d++) begin
                exp_an  = (d == 0) ? 3'b001 : (d == 1) ? 3'b010 : 3'b100;
                exp_seg = (d == 0) ? s0 : (d == 1) ? s1 : s2;
                for (int c = 0; c < 4; c++) begin
                    check("scan_an", {9'd0, an}, {9'd0, exp_an});
                    check("scan_seg", {5'd0, seg}, {5'd0, exp_seg});
                    tick();
                end
            end
        end
    endtask

    initial begin
        int pulses;
        reset = 1'b1;
        load  = 1'b0;
        q_in  = '0;

        // 1. reset state
        tick();
        tick();
        check("rst_busy", {11'd0, busy}, 12'd0);
        check("rst_valid", {11'd0, bcd_valid}, 12'd0);
        check("rst_bcd", bcd, 12'h000);
        check("rst_an", {9'd0, an}, 12'h001);
        check("rst_seg", {5'd0, seg}, 12'h03F);
        reset = 1'b0;
        tick();

        // 2. full-scale value
        do_convert(7'd127, 12'h127);

        // 3. sweep across digit boundaries
        do_convert(7'd0,   12'h000);
        do_convert(7'd9,   12'h009);
        do_convert(7'd10,  12'h010);
        do_convert(7'd99,  12'h099);
        do_convert(7'd100, 12'h100);

        // 4. scan and blanking
        do_convert(7'd105, 12'h105);
        check_scan(7'h6D, 7'h3F, 7'h06, 2);
        do_convert(7'd5, 12'h005);
        check_scan(7'h6D, 7'h00, 7'h00, 1);

        // 5. loads during busy and at the completion edge are ignored
        q_in = 7'd42;
        load = 1'b1;
        tick();
        q_in = 7'd7;
        for (int i = 0; i < 7; i++) begin
            check("ign_busy", {11'd0, busy}, 12'd1);
            tick();
        end
        load = 1'b0;
        check("ign_valid", {11'd0, bcd_valid}, 12'd1);
        check("ign_bcd", bcd, 12'h042);
        check("ign_idle", {11'd0, busy}, 12'd0);
        tick();
        check("ign_no_requeue", {11'd0, busy}, 12'd0);
        check("ign_valid_off", {11'd0, bcd_valid}, 12'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (bcd_valid) pulses++;
            tick();
        end
        check("ign_no_pulse", 12'(pulses), 12'd0);
        check("ign_bcd_hold", bcd, 12'h042);
        check_scan(7'h5B, 7'h66, 7'h00, 1);

        // 6. reset in the third SHIFT cycle
        q_in = 7'd88;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", {11'd0, busy}, 12'd0);
        check("mid_rst_valid", {11'd0, bcd_valid}, 12'd0);
        check("mid_rst_bcd", bcd, 12'h000);
        check("mid_rst_an", {9'd0, an}, 12'h001);
        check("mid_rst_seg", {5'd0, seg}, 12'h03F);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (bcd_valid || busy) pulses++;
            tick();
        end
        check("mid_rst_quiet", 12'(pulses), 12'd0);
        do_convert(7'd88, 12'h088);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
